// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply loader and the thread-unit benches.
package mm_pkg;
  localparam int MM_DIM_W     = 4;
  localparam int MM_DATA_W    = 32;
  localparam int MM_GUARD_CYC = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;
endpackage

// File: rtl/idx2d_counter.sv
// Nested inner/outer index counter walking a matrix in row-major order.
module idx2d_counter
  import mm_pkg::*;
#(
  parameter int DIM_W = MM_DIM_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  input  logic [DIM_W-1:0] inner_max,
  input  logic [DIM_W-1:0] outer_max,
  output logic [DIM_W-1:0] inner,
  output logic [DIM_W-1:0] outer,
  output logic             last
);

  assign last = (inner == inner_max) && (outer == outer_max);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inner <= '0;
      outer <= '0;
    end else if (clr) begin
      inner <= '0;
      outer <= '0;
    end else if (inc) begin
      if (inner == inner_max) begin
        inner <= '0;
        outer <= (outer == outer_max) ? '0 : outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_loader.sv
// Feeds operands of A then B onto the shared thread-unit bus, starts the
// multiply and waits for every thread to report finished.
module mm_loader
  import mm_pkg::*;
#(
  parameter int DIM_W     = MM_DIM_W,
  parameter int DATA_W    = MM_DATA_W,
  parameter int GUARD_CYC = MM_GUARD_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIM_W-1:0]  cfg_a1,
  input  logic [DIM_W-1:0]  cfg_a2,
  input  logic [DIM_W-1:0]  cfg_a3,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DIM_W-1:0]  a1,
  output logic [DIM_W-1:0]  a2,
  output logic [DIM_W-1:0]  a3,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic              readA,
  output logic              readB,
  output logic [DATA_W-1:0] Din,
  output logic              start_mm,
  input  logic              all_finished,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] GUARD_LIM = GUARD_CYC[7:0];

  state_t              state, state_nxt;
  logic [DIM_W-1:0]    a1_nxt, a2_nxt, a3_nxt, row_nxt, col_nxt;
  logic [DATA_W-1:0]   din_nxt;
  logic                read_a_nxt, read_b_nxt, start_nxt, done_nxt, err_nxt, busy_nxt;
  logic [7:0]          guard, guard_nxt;
  logic                accept, cfg_zero;
  logic [DIM_W-1:0]    inner, outer, inner_max, outer_max;
  logic                last;

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign accept    = in_valid && in_ready;
  assign cfg_zero  = (cfg_a1 == '0) || (cfg_a2 == '0) || (cfg_a3 == '0);

  // One counter serves both matrices: A walks a1 x a2, B walks a2 x a3.
  assign inner_max = (state == LOAD_B) ? a3 - 1'b1 : a2 - 1'b1;
  assign outer_max = (state == LOAD_B) ? a2 - 1'b1 : a1 - 1'b1;

  idx2d_counter #(.DIM_W(DIM_W)) u_idx (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc       (accept),
    .clr       (state == IDLE),
    .inner_max (inner_max),
    .outer_max (outer_max),
    .inner     (inner),
    .outer     (outer),
    .last      (last)
  );

  always_comb begin
    state_nxt  = state;
    a1_nxt     = a1;
    a2_nxt     = a2;
    a3_nxt     = a3;
    row_nxt    = row;
    col_nxt    = col;
    din_nxt    = Din;
    read_a_nxt = 1'b0;
    read_b_nxt = 1'b0;
    start_nxt  = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    guard_nxt  = guard;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_zero) begin
            err_nxt = 1'b1;
          end else begin
            a1_nxt    = cfg_a1;
            a2_nxt    = cfg_a2;
            a3_nxt    = cfg_a3;
            state_nxt = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        if (accept) begin
          read_a_nxt = 1'b1;
          row_nxt    = outer;
          col_nxt    = inner;
          din_nxt    = in_data;
          if (last) state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        if (accept) begin
          read_b_nxt = 1'b1;
          row_nxt    = outer;
          col_nxt    = inner;
          din_nxt    = in_data;
          if (last) state_nxt = START;
        end
      end
      START: begin
        start_nxt = 1'b1;
        guard_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Finished levels left over from the previous job are masked here.
        if (guard < GUARD_LIM) begin
          guard_nxt = guard + 1'b1;
        end else if (all_finished) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      a1       <= '0;
      a2       <= '0;
      a3       <= '0;
      row      <= '0;
      col      <= '0;
      Din      <= '0;
      readA    <= 1'b0;
      readB    <= 1'b0;
      start_mm <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      guard    <= '0;
    end else begin
      state    <= state_nxt;
      a1       <= a1_nxt;
      a2       <= a2_nxt;
      a3       <= a3_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      Din      <= din_nxt;
      readA    <= read_a_nxt;
      readB    <= read_b_nxt;
      start_mm <= start_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      guard    <= guard_nxt;
    end
  end

endmodule

// File: tb/tb_mm_loader.sv
// Scoreboard bench for mm_loader: stimulus queues expected bus events, a
// forked monitor pops and compares them as the loader emits them.
module tb_mm_loader;
  import mm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_a1 = '0, cfg_a2 = '0, cfg_a3 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  a1, a2, a3, row, col;
  logic        readA, readB, start_mm, busy, done, err;
  logic [31:0] Din;
  logic        all_finished = 1'b0;

  mm_loader #(.DIM_W(4), .DATA_W(32), .GUARD_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_a1(cfg_a1), .cfg_a2(cfg_a2), .cfg_a3(cfg_a3),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a1(a1), .a2(a2), .a3(a3), .row(row), .col(col),
    .readA(readA), .readB(readB), .Din(Din), .start_mm(start_mm),
    .all_finished(all_finished), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] K_A = 3'd1, K_B = 3'd2, K_S = 3'd3, K_D = 3'd4, K_E = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] data;
    logic        busy;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  na = 0;
  int  nb = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input int r, input int c,
                      input logic [31:0] d, input logic b);
    ev_t e;
    e.kind = k;
    e.row  = r[3:0];
    e.col  = c[3:0];
    e.data = d;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    ev_t act, exp;
    forever begin
      @(negedge clk);
      chk("excl_strobe", {63'd0, readA & readB}, 64'd0);
      if (readA || readB || start_mm || done || err) begin
        act.kind = readA ? K_A : readB ? K_B : start_mm ? K_S : done ? K_D : K_E;
        act.row  = (readA || readB) ? row : 4'd0;
        act.col  = (readA || readB) ? col : 4'd0;
        act.data = (readA || readB) ? Din : 32'd0;
        act.busy = busy;
        if (readA) na++;
        if (readB) nb++;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {20'd0, act}, 64'd0);
        end else begin
          exp = exp_q.pop_front();
          chk("bus_event", {20'd0, act}, {20'd0, exp});
        end
      end
    end
  endtask

  task automatic cfg(input int x1, input int x2, input int x3);
    int n;
    cfg_a1 = x1[3:0];
    cfg_a2 = x2[3:0];
    cfg_a3 = x3[3:0];
    cfg_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_wait", {63'd0, cfg_ready}, 64'd1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [2:0] k, input int r, input int c,
                           input logic [31:0] d, input bit gap);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    push(k, r, c, d, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
      chk("gap_hold", {24'd0, readA, readB, row, col, Din},
          {24'd0, 2'b00, r[3:0], c[3:0], d});
    end
  endtask

  task automatic run_job(input int x1, input int x2, input int x3,
                         input int nb_lim, input bit gap);
    int nbeat;
    cfg(x1, x2, x3);
    for (int i = 0; i < x1; i++)
      for (int k = 0; k < x2; k++)
        send_beat(K_A, i, k, i * x2 + k + 1, gap);
    nbeat = 0;
    for (int k = 0; k < x2; k++)
      for (int j = 0; j < x3; j++)
        if (nb_lim < 0 || nbeat < nb_lim) begin
          send_beat(K_B, k, j, x1 * x2 + k * x3 + j + 1, gap);
          nbeat++;
        end
    if (nb_lim < 0) push(K_S, 0, 0, 32'd0, 1'b1);
  endtask

  task automatic finish_job(input bit early, input bit gap, input int exp_lat);
    int n, t0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start_mm && n < 40);
    chk("start_seen", {63'd0, start_mm}, 64'd1);
    chk("start_lag", n, gap ? 1 : 2);
    t0 = cyc;
    push(K_D, 0, 0, 32'd0, 1'b1);
    if (!early) begin
      repeat (10) @(posedge clk);
      #1 all_finished = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("done_latency", cyc - t0, exp_lat);
    @(posedge clk);
    #1 all_finished = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Power-up reset
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {row, col, Din, readA, readB, start_mm, done, err, busy, a1, a2, a3, cfg_ready, in_ready},
        {46'd0, 12'd0, 1'b1, 1'b0});
    reset_n = 1'b1;

    // 2x3 * 3x2, continuous beats, stale finished held high
    all_finished = 1'b1;
    na = 0;
    nb = 0;
    run_job(2, 3, 2, -1, 1'b0);
    finish_job(1'b1, 1'b0, 3);
    chk("strobes_job1", {na, nb}, {32'd6, 32'd6});
    chk("idle_status", {cfg_ready, busy, a1, a2, a3}, {1'b1, 1'b0, 4'd2, 4'd3, 4'd2});

    // Zero dimension rejected
    push(K_E, 0, 0, 32'd0, 1'b0);
    cfg(0, 3, 2);
    chk("err_status", {err, cfg_ready, busy, in_ready, a1, a2, a3},
        {1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 4'd2});
    @(posedge clk);
    #1;
    chk("err_one_cycle", {err, cfg_ready}, {1'b0, 1'b1});

    // Same job with gaps between beats, finished raised 10 cycles after start
    na = 0;
    nb = 0;
    run_job(2, 3, 2, -1, 1'b1);
    finish_job(1'b0, 1'b1, 11);
    chk("strobes_job2", {na, nb}, {32'd6, 32'd6});

    // Reset in the middle of LOAD_B after the third B beat
    run_job(2, 3, 2, 3, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_mid_job",
        {row, col, Din, readA, readB, start_mm, done, err, busy, a1, a2, a3, cfg_ready, in_ready},
        {46'd0, 12'd0, 1'b1, 1'b0});
    reset_n = 1'b1;
    chk("queue_flushed", exp_q.size(), 0);

    // Fresh job after reset restarts from index zero
    all_finished = 1'b1;
    na = 0;
    nb = 0;
    run_job(2, 3, 2, -1, 1'b0);
    finish_job(1'b1, 1'b0, 3);
    chk("strobes_job3", {na, nb}, {32'd6, 32'd6});

    // Maximum dimensions
    na = 0;
    nb = 0;
    run_job(15, 15, 15, -1, 1'b0);
    finish_job(1'b0, 1'b0, 11);
    chk("strobes_max", {na, nb}, {32'd225, 32'd225});
    chk("final_pos", {row, col}, {4'd14, 4'd14});
    chk("max_dims", {a1, a2, a3}, {4'd15, 4'd15, 4'd15});

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
